// File: rtl/dff_bist.sv
// dff_bist: synthesizable self-test initiator for the lab D flip-flop. Applies NUM_VEC
// clr/set/d vectors, checks Q/Qbar one edge after capture. Optional first-failure capture: DFF_BIST_FAILCAP_EN.
module dff_bist #(
  parameter int NUM_VEC = 16,
  parameter int ERR_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             dut_d,
  output logic             dut_clr,
  output logic             dut_set,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef DFF_BIST_FAILCAP_EN
  ,
  output logic             fail_seen,
  output logic [3:0]       fail_idx
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             clr_nxt, set_nxt, d_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [2:0]       cur_vec;
  logic             exp_q, mism;

  // {clr, set, d} for vector index c; clr/set active-low
  function automatic logic [2:0] vec(input logic [3:0] c);
    logic [2:0] v;
    v[2] = ~(c == 4'd2 || c == 4'd5 || c == 4'd6);
    v[1] = ~(c == 4'd1 || c == 4'd2 || c == 4'd6);
    v[0] = c[2];
    return v;
  endfunction

  // expected Q: clr dominates set, otherwise follows d
  assign cur_vec = vec(idx);
  assign exp_q   = ~cur_vec[2] ? 1'b0 : (~cur_vec[1] ? 1'b1 : cur_vec[0]);
  assign mism    = (dut_q != exp_q) || (dut_qbar != ~exp_q);

`ifdef DFF_BIST_FAILCAP_EN
  logic       fs_nxt;
  logic [3:0] fi_nxt;
`endif

  always_comb begin
    state_nxt                   = state;
    idx_nxt                     = idx;
    {clr_nxt, set_nxt, d_nxt}   = {dut_clr, dut_set, dut_d};
    err_nxt                     = err_cnt;
`ifdef DFF_BIST_FAILCAP_EN
    fs_nxt                      = fail_seen;
    fi_nxt                      = fail_idx;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt                 = DRIVE;
          idx_nxt                   = 4'd0;
          {clr_nxt, set_nxt, d_nxt} = vec(4'd0);
          err_nxt                   = '0;
`ifdef DFF_BIST_FAILCAP_EN
          fs_nxt                    = 1'b0;
          fi_nxt                    = 4'd0;
`endif
        end
      end
      DRIVE: state_nxt = WAIT;
      WAIT: begin
        if (mism && err_cnt != '1) err_nxt = err_cnt + 1'b1;
`ifdef DFF_BIST_FAILCAP_EN
        if (mism && !fail_seen) begin
          fs_nxt = 1'b1;
          fi_nxt = idx;
        end
`endif
        if (idx != LAST) begin
          idx_nxt                   = idx + 4'd1;
          {clr_nxt, set_nxt, d_nxt} = vec(idx + 4'd1);
          state_nxt                 = DRIVE;
        end else begin
          // park the DUT in its cleared state between runs
          {clr_nxt, set_nxt, d_nxt} = 3'b010;
          state_nxt                 = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      dut_clr <= 1'b0;
      dut_set <= 1'b1;
      dut_d   <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dut_clr <= clr_nxt;
      dut_set <= set_nxt;
      dut_d   <= d_nxt;
      err_cnt <= err_nxt;
    end
  end

`ifdef DFF_BIST_FAILCAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_seen <= 1'b0;
      fail_idx  <= 4'd0;
    end else begin
      fail_seen <= fs_nxt;
      fail_idx  <= fi_nxt;
    end
  end
`endif

  assign busy = (state == DRIVE) || (state == WAIT);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);
endmodule

// File: tb/tb_dff_bist.sv
// Self-checking bench for dff_bist: behavioural flip-flop with injectable faults,
// scoreboard of expected run results pushed at start and popped when done rises.
module tb_dff_bist;
  localparam logic [15:0] EXP_SEQ = 16'b1111_0000_1001_0010; // expected Q, bit c

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start16 = 1'b0, start8 = 1'b0;
  int   fault = 0;  // 0 ideal, 1 Q stuck 0, 2 Qbar tied to Q, 3 Q stuck 1

  logic       q16, qb16, d16, clr16, set16, busy16, done16, pass16;
  logic       q8, qb8, d8, clr8, set8, busy8, done8, pass8;
  logic [4:0] err16, err8;
  logic       qm16 = 1'b0, qm8 = 1'b0;
`ifdef DFF_BIST_FAILCAP_EN
  logic       fs16, fs8;
  logic [3:0] fi16, fi8;
`endif

  always #5 clk = ~clk;

  dff_bist u_dut (
    .clk(clk), .rst(rst), .start(start16), .dut_q(q16), .dut_qbar(qb16),
    .dut_d(d16), .dut_clr(clr16), .dut_set(set16), .busy(busy16), .done(done16),
    .pass(pass16), .err_cnt(err16)
`ifdef DFF_BIST_FAILCAP_EN
    , .fail_seen(fs16), .fail_idx(fi16)
`endif
  );

  dff_bist #(.NUM_VEC(8), .ERR_W(5)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .dut_q(q8), .dut_qbar(qb8),
    .dut_d(d8), .dut_clr(clr8), .dut_set(set8), .busy(busy8), .done(done8),
    .pass(pass8), .err_cnt(err8)
`ifdef DFF_BIST_FAILCAP_EN
    , .fail_seen(fs8), .fail_idx(fi8)
`endif
  );

  // flip-flops under test, with fault injection on their outputs
  always @(posedge clk) qm16 <= !clr16 ? 1'b0 : (!set16 ? 1'b1 : d16);
  always @(posedge clk) qm8  <= !clr8  ? 1'b0 : (!set8  ? 1'b1 : d8);
  always_comb begin
    q16  = (fault == 1) ? 1'b0 : (fault == 3) ? 1'b1 : qm16;
    qb16 = (fault == 2) ? q16 : ~q16;
    q8   = (fault == 1) ? 1'b0 : (fault == 3) ? 1'b1 : qm8;
    qb8  = (fault == 2) ? q8 : ~q8;
  end

  // selected-instance view
  logic       sel = 1'b0;
  logic       s_busy, s_done, s_pass, s_clr, s_set, s_d;
  logic [4:0] s_err;
  always_comb begin
    s_busy = sel ? busy8 : busy16;
    s_done = sel ? done8 : done16;
    s_pass = sel ? pass8 : pass16;
    s_clr  = sel ? clr8  : clr16;
    s_set  = sel ? set8  : set16;
    s_d    = sel ? d8    : d16;
    s_err  = sel ? err8  : err16;
  end
`ifdef DFF_BIST_FAILCAP_EN
  logic       s_fs;
  logic [3:0] s_fi;
  always_comb begin
    s_fs = sel ? fs8 : fs16;
    s_fi = sel ? fi8 : fi16;
  end
`endif

  typedef struct packed {
    logic [4:0] err;
    logic       pass;
    logic       fs;
    logic [3:0] fi;
  } res_t;
  res_t sb[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int mode, input int nv);
    res_t r;
    logic e, q, qb;
    r = '0;
    for (int c = 0; c < nv; c++) begin
      e  = EXP_SEQ[c];
      q  = (mode == 1) ? 1'b0 : (mode == 3) ? 1'b1 : e;
      qb = (mode == 2) ? q : ~q;
      if (q !== e || qb !== ~e) begin
        if (!r.fs) begin
          r.fs = 1'b1;
          r.fi = 4'(c);
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start8 = v; else start16 = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_done"}, s_done, 0);
    chk({tag, "_err"},  s_err, 0);
    chk({tag, "_clr"},  s_clr, 0);
    chk({tag, "_set"},  s_set, 1);
    chk({tag, "_d"},    s_d, 0);
`ifdef DFF_BIST_FAILCAP_EN
    chk({tag, "_fs"},   s_fs, 0);
`endif
  endtask

  // One run on the selected instance. repulse re-pulses start at cycles 5 and 20;
  // rst_at >= 0 asserts rst (together with start) so that it is sampled at that edge.
  task automatic run(input logic which, input int mode, input bit repulse, input int rst_at);
    int   nv, c;
    res_t r;
    sel   = which;
    nv    = which ? 8 : 16;
    fault = mode;
    sb.push_back(model(mode, nv));
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    chk("start_done_clr", s_done, 0);
    chk("start_err_clr", s_err, 0);
    for (int n = 0; n <= 2 * nv; n++) begin
      if (n == rst_at) begin
        rst = 1'b0;
        set_start(1'b0);
        chk_idle("midrst");
        void'(sb.pop_back());
        return;
      end
      if (n % 2 == 0 && n < 2 * nv) begin
        c = n / 2;
        chk($sformatf("busy_v%0d", c), s_busy, 1);
        chk($sformatf("clr_v%0d", c), s_clr, !(c == 2 || c == 5 || c == 6));
        chk($sformatf("set_v%0d", c), s_set, !(c == 1 || c == 2 || c == 6));
        chk($sformatf("d_v%0d", c), s_d, (c >> 2) & 1);
      end
      if (n == 2 * nv - 1) chk("done_early", s_done, 0);
      if (n == 2 * nv) begin
        chk("done_latency", s_done, 1);
        chk("busy_end", s_busy, 0);
        chk("stim_park", {s_clr, s_set, s_d}, 3'b010);
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          r = sb.pop_front();
          chk("err_cnt", s_err, r.err);
          chk("pass", s_pass, r.pass);
`ifdef DFF_BIST_FAILCAP_EN
          chk("fail_seen", s_fs, r.fs);
          if (r.fs) chk("fail_idx", s_fi, r.fi);
`endif
        end
        break;
      end
      set_start(repulse && (n == 4 || n == 19));
      if (n == rst_at - 1) begin
        rst = 1'b1;
        set_start(1'b1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; chk_idle("rst16");
    sel = 1'b1; chk_idle("rst8");
    rst = 1'b0;
    run(1'b0, 0, 1'b0, -1);  // ideal
    run(1'b0, 1, 1'b0, -1);  // Q stuck 0 -> 7
    run(1'b0, 0, 1'b1, -1);  // start from DONE, re-pulses ignored
    run(1'b0, 2, 1'b0, -1);  // Qbar tied to Q -> 16
    run(1'b1, 0, 1'b0, -1);  // NUM_VEC=8 ideal
    run(1'b1, 3, 1'b0, -1);  // NUM_VEC=8 Q stuck 1 -> 5
    run(1'b0, 1, 1'b0, 11);  // rst (with start) mid-run
    run(1'b0, 0, 1'b0, -1);  // clean run after reset
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dff_bist.md
Name: dff_bist

Overview:
- Hardware self-test initiator for the lab D flip-flop: drives D/clr/set stimulus into a DFlipFlop instance, samples its Q/Qbar outputs and counts mismatches.
- Sits beside the flip-flop under test on the same clock.
- Replaces bench-only checking with a synthesizable pass/fail result.
- DUT convention: clr and set are active-low; clr dominates set; when both are inactive, Q follows D on the rising edge.

Parameters:
- NUM_VEC, 16, number of vectors applied per run (1..16); vector index c runs 0..NUM_VEC-1.
- ERR_W, 5, width of err_cnt; must hold NUM_VEC.

Ports:
- clk  in  1  system clock, rising edge; shared with the DUT.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- dut_q  in  1  DUT Q.
- dut_qbar  in  1  DUT Qbar.
- dut_d  out  1  registered stimulus D.
- dut_clr  out  1  registered stimulus clear, active-low.
- dut_set  out  1  registered stimulus set, active-low.
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next accepted start or rst.
- pass  out  1  done & (err_cnt == 0).
- err_cnt  out  ERR_W  mismatching vectors in last/current run.

Behaviour:
- Reset values (rst sampled high): state IDLE, dut_clr=0, dut_set=1, dut_d=0, busy=0, done=0, err_cnt=0, vector index=0.
- Vector decode for 4-bit index c:
  - dut_clr = ~(c==2 | c==5 | c==6)
  - dut_set = ~(c==1 | c==2 | c==6)
  - dut_d = c[2]
- Expected Q: 0 if dut_clr=0; else 1 if dut_set=0; else dut_d.
- Expected sequence for c=0..15: 0,1,0,0,1,0,0,1,0,0,0,0,1,1,1,1.
- States: IDLE, DRIVE, WAIT, DONE.
- IDLE/DONE, start=1 at edge E0:
  - go to DRIVE with index 0.
  - Stimulus registers load vector 0.
  - err_cnt cleared, done cleared, busy set.
- DRIVE, vector k: the next edge (E2k+1) is the DUT capture edge; state goes to WAIT. Stimulus holds.
- WAIT, vector k: at edge E2k+2, sample dut_q/dut_qbar.
  - Mismatch if dut_q != expected or dut_qbar != ~expected.
  - On mismatch, err_cnt increments by 1 and saturates at all-ones.
  - If k < NUM_VEC-1: index increments, new stimulus loads, state goes to DRIVE.
  - Otherwise: state goes to DONE, busy=0, done=1. Stimulus returns to its reset values (clr=0, set=1, d=0).
- Latency: two cycles per vector. done is visible after edge E(2*NUM_VEC) (32 edges after start for default).
- err_cnt is final in the same cycle done rises.
- start while busy: ignored, no restart, no effect on count.
- start in DONE: new run, identical to IDLE.
- rst mid-run: immediate return to reset values at that edge; partial count discarded.
- rst has priority over start in the same cycle.
- Expected-value decode is combinational from the index register.
- The DUT sees only registered outputs, so there are no glitches on dut_clr/dut_set.

Optional Feature:
- Macro DFF_BIST_FAILCAP_EN.
- Defined: add outputs fail_seen (1 bit) and fail_idx (4 bits).
  - At the first mismatch of a run, fail_idx latches k and fail_seen sets.
  - Later mismatches in the same run do not change either output.
  - Both clear on accepted start and on rst (reset values 0).
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Ideal DFF model attached, pulse start → busy for 32 cycles, then done=1, pass=1, err_cnt=0; dut_clr/dut_set/dut_d sequence matches decode for c=0..15.
- DUT Q stuck at 0, Qbar=~Q → err_cnt=7 (c=1,4,7,12,13,14,15), pass=0; with FAILCAP: fail_seen=1, fail_idx=1.
- Qbar tied to Q (otherwise ideal) → every vector fails, err_cnt=16, pass=0; with FAILCAP: fail_idx=0.
- NUM_VEC=8, ideal DUT → done after 16 cycles, err_cnt=0. Stuck-at-1 Q with NUM_VEC=8 → err_cnt=5 (c=0,2,3,5,6).
- start re-pulsed at cycles 5 and 20 of a run → ignored, done still at cycle 32. start pulsed in DONE → err_cnt and done clear, new 32-cycle run.
- rst asserted at cycle 11 of a run → next cycle state IDLE, busy=0, done=0, err_cnt=0, dut_clr=0, dut_set=1, dut_d=0. Following start → full clean run.
